// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; a word accepted at edge k starts its frame at edge k+1, and frames run back-to-back.
// Backpressure: o_txReady = !full from registered count; a pop cannot raise it in the same cycle.
module uart_tx_fifo #(
    parameter int CLOCK_SPEED = 1000000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_txValid,
    input  logic [DATA_BITS-1:0]          i_txData,
    output logic                          o_txReady,
    output logic                          o_txBusy,
    output logic                          o_txSerial,
    output logic                          o_txDone,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifoCount
);

    localparam int CPB = CLOCK_SPEED / BAUD_RATE;
    localparam int CW  = $clog2(CPB);
    localparam int PW  = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   serial_q, serial_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW:0]            count_q, count_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

    logic                   full, empty, bit_end, frame_end, push, pop;
    logic [DATA_BITS-1:0]   head;

    assign full      = (count_q == (PW+1)'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign bit_end   = (cnt_q == CW'(CPB - 1));
    assign frame_end = (state_q == S_STOP) && bit_end && (idx_q == 4'(STOP_BITS - 1));
    assign push      = i_txValid && !full;
    assign pop       = !empty && ((state_q == S_IDLE) || frame_end);
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        par_d    = par_q;
        serial_d = serial_q;
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        end
        case (state_q)
            S_IDLE: begin
                serial_d = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    state_d  = S_DATA;
                    idx_d    = '0;
                    serial_d = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == 4'(DATA_BITS - 1)) begin
                        idx_d = '0;
                        if (PARITY != 0) begin
                            state_d  = S_PARITY;
                            serial_d = par_q;
                        end else begin
                            state_d  = S_STOP;
                            serial_d = 1'b1;
                        end
                    end else begin
                        idx_d    = idx_q + 4'd1;
                        shift_d  = shift_q >> 1;
                        serial_d = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d  = S_STOP;
                    idx_d    = '0;
                    serial_d = 1'b1;
                end
            end
            S_STOP: begin
                if (frame_end) begin
                    state_d  = S_IDLE;
                    serial_d = 1'b1;
                end else if (bit_end) begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                serial_d = 1'b1;
            end
        endcase
        // A pop always launches a start bit at the same edge, from IDLE or straight out of STOP.
        if (pop) begin
            state_d  = S_START;
            serial_d = 1'b0;
            cnt_d    = '0;
            shift_d  = head;
            par_d    = (^head) ^ (PARITY == 2);
        end
    end

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            serial_q <= 1'b1;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            serial_q <= serial_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clock) begin
        if (push && !i_reset) begin
            mem_q[wr_ptr_q] <= i_txData;
        end
    end

    assign o_txReady   = !full;
    assign o_txBusy    = (state_q != S_IDLE) || !empty;
    assign o_txSerial  = serial_q;
    assign o_txDone    = frame_end;
    assign o_fifoCount = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1, 7O2, 8E1 and 8O1 instances at 10 clocks per bit.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    int         n_cmp;
    int         n_err;

    logic       a_valid;
    logic [7:0] a_data;
    logic       a_ready, a_busy, a_serial, a_done;
    logic [2:0] a_count;

    logic       b_valid;
    logic [6:0] b_data;
    logic       b_ready, b_busy, b_serial, b_done;
    logic [2:0] b_count;

    logic       p_valid;
    logic [7:0] p_data;
    logic       c_ready, c_busy, c_serial, c_done;
    logic [2:0] c_count;
    logic       d_ready, d_busy, d_serial, d_done;
    logic [2:0] d_count;

    uart_tx_fifo #(.CLOCK_SPEED(96000), .BAUD_RATE(9600), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .i_clock(clk), .i_reset(rst), .i_txValid(a_valid), .i_txData(a_data),
        .o_txReady(a_ready), .o_txBusy(a_busy), .o_txSerial(a_serial),
        .o_txDone(a_done), .o_fifoCount(a_count));

    uart_tx_fifo #(.CLOCK_SPEED(96000), .BAUD_RATE(9600), .DATA_BITS(7), .PARITY(2),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_txValid(b_valid), .i_txData(b_data),
        .o_txReady(b_ready), .o_txBusy(b_busy), .o_txSerial(b_serial),
        .o_txDone(b_done), .o_fifoCount(b_count));

    uart_tx_fifo #(.CLOCK_SPEED(96000), .BAUD_RATE(9600), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
        .i_clock(clk), .i_reset(rst), .i_txValid(p_valid), .i_txData(p_data),
        .o_txReady(c_ready), .o_txBusy(c_busy), .o_txSerial(c_serial),
        .o_txDone(c_done), .o_fifoCount(c_count));

    uart_tx_fifo #(.CLOCK_SPEED(96000), .BAUD_RATE(9600), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) dut_d (
        .i_clock(clk), .i_reset(rst), .i_txValid(p_valid), .i_txData(p_data),
        .o_txReady(d_ready), .o_txBusy(d_busy), .o_txSerial(d_serial),
        .o_txDone(d_done), .o_fifoCount(d_count));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; p_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_valid = 1'b1; a_data = 8'h5A; b_valid = 1'b0; b_data = '0;
        p_valid = 1'b0; p_data = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (a_serial !== 1'b1) begin n_err++; $display("FAIL rst_serial got %b want 1", a_serial); end
        n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", a_ready); end
        n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", a_busy); end
        n_cmp++; if (a_done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", a_done); end
        n_cmp++; if (a_count !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", a_count); end
        n_cmp++; if (b_serial !== 1'b1 || b_busy !== 1'b0) begin n_err++; $display("FAIL rst_b serial=%b busy=%b want 1/0", b_serial, b_busy); end
        a_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (a_count !== 3'd0 || a_serial !== 1'b1) begin n_err++; $display("FAIL rst_release count=%0d serial=%b want 0/1", a_count, a_serial); end
    endtask

    task automatic test_frame_8n1();
        logic [9:0] exp_bits;
        exp_bits = {1'b1, 8'hA5, 1'b0};
        apply_reset();
        @(negedge clk);
        a_valid = 1'b1; a_data = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0; a_data = 8'h00;
        n_cmp++; if (a_count !== 3'd1 || a_serial !== 1'b1 || a_busy !== 1'b1) begin
            n_err++; $display("FAIL t1_accept count=%0d serial=%b busy=%b want 1/1/1", a_count, a_serial, a_busy); end
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            n_cmp++; if (a_serial !== exp_bits[c/10]) begin n_err++; $display("FAIL t1_serial c=%0d got %b want %b", c, a_serial, exp_bits[c/10]); end
            n_cmp++; if (a_done !== (c == 99)) begin n_err++; $display("FAIL t1_done c=%0d got %b want %b", c, a_done, (c == 99)); end
        end
        @(negedge clk);
        n_cmp++; if (a_serial !== 1'b1 || a_busy !== 1'b0 || a_done !== 1'b0) begin
            n_err++; $display("FAIL t1_idle serial=%b busy=%b done=%b want 1/0/0", a_serial, a_busy, a_done); end
    endtask

    task automatic test_frame_7o2();
        logic [10:0] exp_bits;
        exp_bits = {2'b11, 1'b1, 7'h41, 1'b0};
        apply_reset();
        @(negedge clk);
        b_valid = 1'b1; b_data = 7'h41;
        @(posedge clk);
        @(negedge clk);
        b_valid = 1'b0; b_data = 7'h00;
        for (int c = 0; c < 110; c++) begin
            @(negedge clk);
            n_cmp++; if (b_serial !== exp_bits[c/10]) begin n_err++; $display("FAIL t2_serial c=%0d got %b want %b", c, b_serial, exp_bits[c/10]); end
            n_cmp++; if (b_done !== (c == 109)) begin n_err++; $display("FAIL t2_done c=%0d got %b want %b", c, b_done, (c == 109)); end
        end
        @(negedge clk);
        n_cmp++; if (b_serial !== 1'b1 || b_busy !== 1'b0) begin n_err++; $display("FAIL t2_idle serial=%b busy=%b want 1/0", b_serial, b_busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w [6];
        w[0] = 8'h01; w[1] = 8'h80; w[2] = 8'h3C; w[3] = 8'hC3; w[4] = 8'h55; w[5] = 8'hFF;
        apply_reset();
        @(negedge clk);
        a_valid = 1'b1; a_data = w[0];
        fork
            begin
                int  idx;
                int  budget;
                logic acc;
                idx = 0; budget = 0;
                while (idx < 6 && budget < 1000) begin
                    acc = a_ready;
                    @(posedge clk);
                    @(negedge clk);
                    budget++;
                    if (acc) begin
                        idx++;
                        if (idx == 5) begin
                            n_cmp++; if (a_ready !== 1'b0 || a_count !== 3'd4) begin
                                n_err++; $display("FAIL t3_full ready=%b count=%0d want 0/4", a_ready, a_count); end
                        end
                        if (idx < 6) a_data = w[idx];
                        else a_valid = 1'b0;
                    end
                end
                n_cmp++; if (idx != 6) begin n_err++; $display("FAIL t3_accepted got %0d want 6", idx); a_valid = 1'b0; end
            end
            begin
                bit         seen;
                logic [9:0] frm;
                seen = 1'b0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clk);
                    if (a_serial === 1'b0) seen = 1'b1;
                end
                n_cmp++; if (!seen) begin n_err++; $display("FAIL t3_start got none want start within 20"); end
                if (seen) begin
                    for (int c = 0; c < 600; c++) begin
                        if (c != 0) @(negedge clk);
                        frm = {1'b1, w[c/100], 1'b0};
                        n_cmp++; if (a_serial !== frm[(c%100)/10]) begin n_err++; $display("FAIL t3_serial c=%0d got %b want %b", c, a_serial, frm[(c%100)/10]); end
                        n_cmp++; if (a_done !== ((c % 100) == 99)) begin n_err++; $display("FAIL t3_done c=%0d got %b want %b", c, a_done, ((c % 100) == 99)); end
                    end
                    @(negedge clk);
                    n_cmp++; if (a_serial !== 1'b1 || a_busy !== 1'b0) begin n_err++; $display("FAIL t3_idle serial=%b busy=%b want 1/0", a_serial, a_busy); end
                end
            end
        join
    endtask

    task automatic test_full_pop_push();
        int   idx;
        int   budget;
        logic acc;
        bit   hit;
        apply_reset();
        @(negedge clk);
        a_valid = 1'b1; a_data = 8'h10; idx = 0; budget = 0;
        while (idx < 5 && budget < 50) begin
            acc = a_ready;
            @(posedge clk);
            @(negedge clk);
            budget++;
            if (acc) begin idx++; a_data = 8'h10 + 8'(idx); end
        end
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (a_done === 1'b1) hit = 1'b1;
            else @(negedge clk);
        end
        n_cmp++; if (!hit) begin n_err++; $display("FAIL t4_done got none want pulse within 200"); end
        if (hit) begin
            n_cmp++; if (a_count !== 3'd4 || a_ready !== 1'b0) begin n_err++; $display("FAIL t4_before count=%0d ready=%b want 4/0", a_count, a_ready); end
            @(negedge clk);
            n_cmp++; if (a_count !== 3'd3 || a_ready !== 1'b1) begin n_err++; $display("FAIL t4_pop count=%0d ready=%b want 3/1", a_count, a_ready); end
            n_cmp++; if (a_serial !== 1'b0) begin n_err++; $display("FAIL t4_nogap got %b want 0", a_serial); end
            @(negedge clk);
            n_cmp++; if (a_count !== 3'd4 || a_ready !== 1'b0) begin n_err++; $display("FAIL t4_push count=%0d ready=%b want 4/0", a_count, a_ready); end
        end
        a_valid = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int lows;
        int busys;
        apply_reset();
        @(negedge clk);
        a_valid = 1'b1; a_data = 8'h00;
        @(posedge clk); @(negedge clk);
        a_data = 8'h11;
        @(posedge clk); @(negedge clk);
        a_data = 8'h22;
        @(posedge clk); @(negedge clk);
        a_valid = 1'b0;
        n_cmp++; if (a_count !== 3'd2) begin n_err++; $display("FAIL t5_queued got %0d want 2", a_count); end
        repeat (44) @(negedge clk);
        n_cmp++; if (a_serial !== 1'b0 || a_busy !== 1'b1) begin n_err++; $display("FAIL t5_bit3 serial=%b busy=%b want 0/1", a_serial, a_busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (a_serial !== 1'b1) begin n_err++; $display("FAIL t5_serial got %b want 1", a_serial); end
        n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL t5_busy got %b want 0", a_busy); end
        n_cmp++; if (a_count !== 3'd0) begin n_err++; $display("FAIL t5_count got %0d want 0", a_count); end
        n_cmp++; if (a_ready !== 1'b1 || a_done !== 1'b0) begin n_err++; $display("FAIL t5_ready_done ready=%b done=%b want 1/0", a_ready, a_done); end
        lows = 0; busys = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (a_serial !== 1'b1) lows++;
            if (a_busy !== 1'b0) busys++;
        end
        n_cmp++; if (lows != 0 || busys != 0) begin n_err++; $display("FAIL t5_quiet low_cycles=%0d busy_cycles=%0d want 0/0", lows, busys); end
    endtask

    task automatic test_parity();
        apply_reset();
        @(negedge clk);
        p_valid = 1'b1; p_data = 8'h00;
        @(posedge clk); @(negedge clk);
        p_data = 8'hFF;
        @(posedge clk); @(negedge clk);
        p_valid = 1'b0;
        n_cmp++; if (c_serial !== 1'b0 || d_serial !== 1'b0) begin n_err++; $display("FAIL t6_start even=%b odd=%b want 0/0", c_serial, d_serial); end
        repeat (85) @(negedge clk);
        n_cmp++; if (c_serial !== 1'b0) begin n_err++; $display("FAIL t6_d7_00 got %b want 0", c_serial); end
        repeat (10) @(negedge clk);
        n_cmp++; if (c_serial !== 1'b0) begin n_err++; $display("FAIL t6_even_00 got %b want 0", c_serial); end
        n_cmp++; if (d_serial !== 1'b1) begin n_err++; $display("FAIL t6_odd_00 got %b want 1", d_serial); end
        repeat (10) @(negedge clk);
        n_cmp++; if (c_serial !== 1'b1 || d_serial !== 1'b1) begin n_err++; $display("FAIL t6_stop1 even=%b odd=%b want 1/1", c_serial, d_serial); end
        repeat (10) @(negedge clk);
        n_cmp++; if (c_serial !== 1'b0) begin n_err++; $display("FAIL t6_start2 got %b want 0", c_serial); end
        repeat (80) @(negedge clk);
        n_cmp++; if (c_serial !== 1'b1) begin n_err++; $display("FAIL t6_d7_ff got %b want 1", c_serial); end
        repeat (10) @(negedge clk);
        n_cmp++; if (c_serial !== 1'b0) begin n_err++; $display("FAIL t6_even_ff got %b want 0", c_serial); end
        n_cmp++; if (d_serial !== 1'b1) begin n_err++; $display("FAIL t6_odd_ff got %b want 1", d_serial); end
        repeat (15) @(negedge clk);
        n_cmp++; if (c_busy !== 1'b0 || d_busy !== 1'b0 || c_serial !== 1'b1) begin
            n_err++; $display("FAIL t6_idle busy=%b/%b serial=%b want 0/0/1", c_busy, d_busy, c_serial); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        test_reset();
        test_frame_8n1();
        test_frame_7o2();
        test_back_to_back();
        test_full_pop_push();
        test_reset_midframe();
        test_parity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
